// File: rtl/prime_stream_engine.sv
// Prime search engine: trial division against an on-chip prime table,
// streaming each prime over valid/ready and replaying the table on request.
module prime_stream_engine #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 10
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     Start,
    input  logic                     Replay,
    input  logic [ADDRESS_WIDTH:0]   Target,
    input  logic                     Ready,
    output logic                     Valid,
    output logic [DATA_WIDTH-1:0]    Data,
    output logic [ADDRESS_WIDTH:0]   Count,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Error
);

    localparam int RAM_DEPTH = 1 << ADDRESS_WIDTH;
    localparam int CW = ADDRESS_WIDTH + 1;
    localparam int DW = DATA_WIDTH;
    localparam int BW = $clog2(DATA_WIDTH);

    localparam logic [CW-1:0] ONE_C    = CW'(1);
    localparam logic [BW-1:0] ONE_B    = BW'(1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic [DW-1:0] TWO      = DW'(2);
    localparam logic [DW-1:0] THREE    = DW'(3);
    localparam logic [CW:0]   DEPTH_W  = RAM_DEPTH[CW:0];

    typedef enum logic [2:0] {
        S_IDLE, S_SEED, S_FETCH, S_DIVIDE,
        S_EMIT, S_NEXT, S_DONE, S_REPLAY
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] target_q, target_d;
    logic [CW-1:0] k_q, k_d;
    logic [DW-1:0] cand_q, cand_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] rem_q, rem_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          error_q, error_d;

    logic [DW-1:0] mem [RAM_DEPTH];
    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DW-1:0]            wr_data;

    logic [DW-1:0]   rd_data;
    logic [2*DW-1:0] p_ext;
    logic [2*DW-1:0] p_sq;
    logic [2*DW-1:0] cand_ext;
    logic [DW:0]     rem_sh;
    logic [DW:0]     div_ext;
    logic [DW:0]     rem_nx;
    logic [DW:0]     cand_sum;
    logic            tgt_bad;

    assign rd_data  = mem[k_q[ADDRESS_WIDTH-1:0]];
    assign p_ext    = {{DW{1'b0}}, rd_data};
    assign p_sq     = p_ext * p_ext;
    assign cand_ext = {{DW{1'b0}}, cand_q};

    // One restoring step: shift in the next dividend bit, subtract if it fits
    assign rem_sh  = {rem_q, dvd_q[DW-1]};
    assign div_ext = {1'b0, div_q};
    assign rem_nx  = (rem_sh >= div_ext) ? rem_sh - div_ext : rem_sh;

    // Carry out means the next odd candidate no longer fits in DATA_WIDTH
    assign cand_sum = {1'b0, cand_q} + {{(DW-1){1'b0}}, 2'b10};

    assign tgt_bad = (Target == '0) || ({1'b0, Target} > DEPTH_W);

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        target_d = target_q;
        k_d      = k_q;
        cand_d   = cand_q;
        div_d    = div_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        bit_d    = bit_q;
        valid_d  = valid_q;
        data_d   = data_q;
        error_d  = error_q;
        wr_en    = 1'b0;
        wr_addr  = count_q[ADDRESS_WIDTH-1:0];
        wr_data  = cand_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    count_d = '0;
                    if (tgt_bad) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        error_d  = 1'b0;
                        target_d = Target;
                        state_d  = S_SEED;
                    end
                end else if (Replay && state_q == S_DONE) begin
                    k_d     = '0;
                    state_d = S_REPLAY;
                end
            end
            S_SEED: begin
                if (!valid_q) begin
                    wr_en   = 1'b1;
                    wr_addr = '0;
                    wr_data = TWO;
                    count_d = ONE_C;
                    valid_d = 1'b1;
                    data_d  = TWO;
                    cand_d  = THREE;
                end else if (Ready) begin
                    valid_d = 1'b0;
                    k_d     = ONE_C;
                    state_d = (target_q == ONE_C) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (k_q == count_q || p_sq > cand_ext) begin
                    state_d = S_EMIT;
                end else begin
                    div_d   = rd_data;
                    dvd_d   = cand_q;
                    rem_d   = '0;
                    bit_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                rem_d = rem_nx[DW-1:0];
                dvd_d = {dvd_q[DW-2:0], 1'b0};
                bit_d = bit_q + ONE_B;
                if (bit_q == LAST_BIT) begin
                    if (rem_nx == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        k_d     = k_q + ONE_C;
                        state_d = S_FETCH;
                    end
                end
            end
            S_EMIT: begin
                if (!valid_q) begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE_C;
                    valid_d = 1'b1;
                    data_d  = cand_q;
                end else if (Ready) begin
                    valid_d = 1'b0;
                    state_d = (count_q == target_q) ? S_DONE : S_NEXT;
                end
            end
            S_NEXT: begin
                if (cand_sum[DW]) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cand_d  = cand_sum[DW-1:0];
                    k_d     = ONE_C;
                    state_d = S_FETCH;
                end
            end
            S_REPLAY: begin
                if (!valid_q) begin
                    if (k_q == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        valid_d = 1'b1;
                        data_d  = rd_data;
                    end
                end else if (Ready) begin
                    valid_d = 1'b0;
                    k_d     = k_q + ONE_C;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            target_q <= '0;
            k_q      <= '0;
            cand_q   <= '0;
            div_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            bit_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            target_q <= target_d;
            k_q      <= k_d;
            cand_q   <= cand_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            bit_q    <= bit_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            error_q  <= error_d;
        end
    end

    assign Valid = valid_q;
    assign Data  = data_q;
    assign Count = count_q;
    assign Busy  = !(state_q == S_IDLE || state_q == S_DONE);
    assign Done  = (state_q == S_DONE);
    assign Error = error_q;

endmodule

// File: tb/tb_prime_stream_engine.sv
// Directed bench for prime_stream_engine: default-width instance for the
// main scenarios plus a 4-bit instance for candidate overflow.
module tb_prime_stream_engine;

    logic        Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Rst, Start, Replay, Ready;
    logic [10:0] Target;
    logic        Valid;
    logic [15:0] Data;
    logic [10:0] Count;
    logic        Busy, Done, Error;

    logic        s_rst, s_start, s_replay, s_ready;
    logic [4:0]  s_target;
    logic        s_valid;
    logic [3:0]  s_data;
    logic [4:0]  s_count;
    logic        s_busy, s_done, s_error;

    prime_stream_engine u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .Replay(Replay),
        .Target(Target), .Ready(Ready), .Valid(Valid), .Data(Data),
        .Count(Count), .Busy(Busy), .Done(Done), .Error(Error)
    );

    prime_stream_engine #(.DATA_WIDTH(4), .ADDRESS_WIDTH(4)) u_small (
        .Clk(Clk), .Rst(s_rst), .Start(s_start), .Replay(s_replay),
        .Target(s_target), .Ready(s_ready), .Valid(s_valid), .Data(s_data),
        .Count(s_count), .Busy(s_busy), .Done(s_done), .Error(s_error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit toggle   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit is_prime(input int n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= n; d++) begin
            if (n % d == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int next_prime(input int p);
        int c;
        c = p + 1;
        while (!is_prime(c)) c++;
        return c;
    endfunction

    task automatic recv(input int exp, input string tag);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(negedge Clk);
            Ready = toggle ? ~Ready : 1'b1;
            if (Valid && Ready) got = 1'b1;
            n++;
        end
        chk({tag, "_xfer"}, 32'(got), 32'd1);
        chk(tag, 32'(Data), 32'(exp));
    endtask

    task automatic recv_s(input int exp, input string tag);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 500) begin
            @(negedge Clk);
            if (s_valid && s_ready) got = 1'b1;
            n++;
        end
        chk({tag, "_xfer"}, 32'(got), 32'd1);
        chk(tag, 32'(s_data), 32'(exp));
    endtask

    task automatic wait_done(input string tag);
        bit got;
        int n;
        got = 1'b0;
        n = 0;
        while (!got && n < 3000) begin
            @(negedge Clk);
            if (Done) got = 1'b1;
            n++;
        end
        chk(tag, 32'(got), 32'd1);
    endtask

    task automatic pulse_start(input logic [10:0] t);
        @(negedge Clk);
        Target = t;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    initial begin
        bit saw;
        int p;
        int n;
        Rst = 1'b1; Start = 1'b0; Replay = 1'b0; Ready = 1'b0; Target = '0;
        s_rst = 1'b1; s_start = 1'b0; s_replay = 1'b0; s_ready = 1'b1;
        s_target = '0;
        repeat (3) @(negedge Clk);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_data",  32'(Data),  32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_busy",  32'(Busy),  32'd0);
        chk("rst_done",  32'(Done),  32'd0);
        chk("rst_error", 32'(Error), 32'd0);
        Rst = 1'b0;
        s_rst = 1'b0;

        // Test 1: basic run of five primes
        toggle = 1'b0;
        Ready = 1'b1;
        pulse_start(11'd5);
        chk("t1_busy", 32'(Busy), 32'd1);
        recv(2,  "t1_p0");
        recv(3,  "t1_p1");
        recv(5,  "t1_p2");
        recv(7,  "t1_p3");
        recv(11, "t1_p4");
        wait_done("t1_done");
        chk("t1_count", 32'(Count), 32'd5);
        chk("t1_error", 32'(Error), 32'd0);
        chk("t1_busy_end", 32'(Busy), 32'd0);
        chk("t1_valid_end", 32'(Valid), 32'd0);

        // Test 4: replay with toggling Ready, Start ignored mid-replay
        Ready = 1'b0;
        @(negedge Clk);
        Replay = 1'b1;
        @(negedge Clk);
        Replay = 1'b0;
        Target = 11'd3;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        chk("t4_busy", 32'(Busy), 32'd1);
        toggle = 1'b1;
        recv(2,  "t4_p0");
        recv(3,  "t4_p1");
        recv(5,  "t4_p2");
        recv(7,  "t4_p3");
        recv(11, "t4_p4");
        toggle = 1'b0;
        wait_done("t4_done");
        chk("t4_count", 32'(Count), 32'd5);
        chk("t4_error", 32'(Error), 32'd0);
        chk("t4_valid_end", 32'(Valid), 32'd0);

        // Test 2: backpressure on the first prime
        Ready = 1'b0;
        pulse_start(11'd5);
        saw = 1'b0;
        n = 0;
        while (!saw && n < 50) begin
            @(negedge Clk);
            if (Valid) saw = 1'b1;
            n++;
        end
        chk("t2_first_valid", 32'(saw), 32'd1);
        repeat (20) @(negedge Clk);
        chk("t2_hold_valid", 32'(Valid), 32'd1);
        chk("t2_hold_data",  32'(Data),  32'd2);
        chk("t2_hold_count", 32'(Count), 32'd1);
        recv(2,  "t2_p0");
        recv(3,  "t2_p1");
        recv(5,  "t2_p2");
        recv(7,  "t2_p3");
        recv(11, "t2_p4");
        wait_done("t2_done");
        chk("t2_count", 32'(Count), 32'd5);

        // Test 5: illegal targets, then recovery
        saw = 1'b0;
        pulse_start(11'd0);
        repeat (4) begin
            @(negedge Clk);
            saw = saw | Valid;
        end
        chk("t5a_done",  32'(Done),  32'd1);
        chk("t5a_error", 32'(Error), 32'd1);
        chk("t5a_count", 32'(Count), 32'd0);
        chk("t5a_valid", 32'(saw),   32'd0);
        saw = 1'b0;
        pulse_start(11'd1025);
        repeat (4) begin
            @(negedge Clk);
            saw = saw | Valid;
        end
        chk("t5b_done",  32'(Done),  32'd1);
        chk("t5b_error", 32'(Error), 32'd1);
        chk("t5b_count", 32'(Count), 32'd0);
        chk("t5b_valid", 32'(saw),   32'd0);
        pulse_start(11'd3);
        chk("t5c_error_clr", 32'(Error), 32'd0);
        recv(2, "t5c_p0");
        recv(3, "t5c_p1");
        recv(5, "t5c_p2");
        wait_done("t5c_done");
        chk("t5c_count", 32'(Count), 32'd3);
        chk("t5c_error", 32'(Error), 32'd0);

        // Test 3: 4-bit candidates run out before the target is met
        @(negedge Clk);
        s_target = 5'd10;
        s_start = 1'b1;
        @(negedge Clk);
        s_start = 1'b0;
        recv_s(2,  "t3_p0");
        recv_s(3,  "t3_p1");
        recv_s(5,  "t3_p2");
        recv_s(7,  "t3_p3");
        recv_s(11, "t3_p4");
        recv_s(13, "t3_p5");
        saw = 1'b0;
        n = 0;
        while (!saw && n < 500) begin
            @(negedge Clk);
            if (s_done) saw = 1'b1;
            n++;
        end
        chk("t3_done",  32'(saw),     32'd1);
        chk("t3_error", 32'(s_error), 32'd1);
        chk("t3_count", 32'(s_count), 32'd6);
        chk("t3_valid", 32'(s_valid), 32'd0);

        // Test 6: reset mid-stream, then a fresh longer run
        pulse_start(11'd100);
        p = 2;
        for (int i = 0; i < 50; i++) begin
            recv(p, $sformatf("t6a_p%0d", i));
            p = next_prime(p);
        end
        @(posedge Clk);
        #1 Rst = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(Valid), 32'd0);
        chk("t6_rst_data",  32'(Data),  32'd0);
        chk("t6_rst_count", 32'(Count), 32'd0);
        chk("t6_rst_busy",  32'(Busy),  32'd0);
        chk("t6_rst_done",  32'(Done),  32'd0);
        chk("t6_rst_error", 32'(Error), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        pulse_start(11'd100);
        p = 2;
        for (int i = 0; i < 100; i++) begin
            recv(p, $sformatf("t6b_p%0d", i));
            p = next_prime(p);
        end
        chk("t6_last", 32'(Data), 32'd541);
        wait_done("t6_done");
        chk("t6_count", 32'(Count), 32'd100);
        chk("t6_error", 32'(Error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
